// File: rtl/i2s_frame_scheduler.sv
// Dual PCM5102A I2S frame scheduler: one sample triple per frame, L/R on DAC1,
// Center on both slots of DAC2, zero-filled frames when the producer underruns.
module i2s_frame_scheduler #(
  parameter int SAMPLE_W = 16,
  parameter int BCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic [SAMPLE_W-1:0] sample_c,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                bck_dac1,
  output logic                lck_dac1,
  output logic                din_dac1,
  output logic                bck_dac2,
  output logic                lck_dac2,
  output logic                din_dac2,
  output logic                busy,
  output logic                underrun,
  output logic [15:0]         underrun_cnt
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int SLOT_W  = (FRAME_W > 2) ? $clog2(FRAME_W) : 1;
  localparam int DIV_W   = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_W - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(SAMPLE_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t              state_reg, state_next;
  logic [DIV_W-1:0]    div_reg, div_next;
  logic                bck_reg, bck_next;
  logic [SLOT_W-1:0]   slot_reg, slot_next;
  logic                lck_reg, lck_next;
  logic                din1_reg, din1_next;
  logic                din2_reg, din2_next;
  logic [FRAME_W-1:0]  sh1_reg, sh1_next;
  logic [FRAME_W-1:0]  sh2_reg, sh2_next;
  logic [SAMPLE_W-1:0] hold_l_reg, hold_l_next;
  logic [SAMPLE_W-1:0] hold_r_reg, hold_r_next;
  logic [SAMPLE_W-1:0] hold_c_reg, hold_c_next;
  logic                hold_full_reg, hold_full_next;
  logic                ready_reg, ready_next;
  logic                busy_reg, busy_next;
  logic                underrun_reg, underrun_next;
  logic [15:0]         underrun_cnt_reg, underrun_cnt_next;

  logic                tick;
  logic                fall;
  logic                accept;
  logic                frame_load;
  logic                take;
  logic [SLOT_W-1:0]   slot_inc;

  assign tick     = (div_reg == DIV_LAST);
  assign fall     = tick & bck_reg;
  assign accept   = sample_valid & ready_reg;
  assign slot_inc = slot_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      div_reg          <= '0;
      bck_reg          <= 1'b0;
      slot_reg         <= '0;
      lck_reg          <= 1'b0;
      din1_reg         <= 1'b0;
      din2_reg         <= 1'b0;
      sh1_reg          <= '0;
      sh2_reg          <= '0;
      hold_l_reg       <= '0;
      hold_r_reg       <= '0;
      hold_c_reg       <= '0;
      hold_full_reg    <= 1'b0;
      ready_reg        <= 1'b1;
      busy_reg         <= 1'b0;
      underrun_reg     <= 1'b0;
      underrun_cnt_reg <= '0;
    end else begin
      state_reg        <= state_next;
      div_reg          <= div_next;
      bck_reg          <= bck_next;
      slot_reg         <= slot_next;
      lck_reg          <= lck_next;
      din1_reg         <= din1_next;
      din2_reg         <= din2_next;
      sh1_reg          <= sh1_next;
      sh2_reg          <= sh2_next;
      hold_l_reg       <= hold_l_next;
      hold_r_reg       <= hold_r_next;
      hold_c_reg       <= hold_c_next;
      hold_full_reg    <= hold_full_next;
      ready_reg        <= ready_next;
      busy_reg         <= busy_next;
      underrun_reg     <= underrun_next;
      underrun_cnt_reg <= underrun_cnt_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    div_next          = div_reg;
    bck_next          = bck_reg;
    slot_next         = slot_reg;
    lck_next          = lck_reg;
    din1_next         = din1_reg;
    din2_next         = din2_reg;
    sh1_next          = sh1_reg;
    sh2_next          = sh2_reg;
    hold_l_next       = hold_l_reg;
    hold_r_next       = hold_r_reg;
    hold_c_next       = hold_c_reg;
    hold_full_next    = hold_full_reg;
    underrun_next     = 1'b0;
    underrun_cnt_next = underrun_cnt_reg;
    frame_load        = 1'b0;
    take              = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        div_next  = '0;
        bck_next  = 1'b0;
        slot_next = '0;
        lck_next  = 1'b0;
        din1_next = 1'b0;
        din2_next = 1'b0;
        if (en) state_next = ST_WAIT;
      end

      ST_WAIT: begin
        if (!en) begin
          state_next = ST_IDLE;
        end else if (hold_full_reg) begin
          state_next = ST_RUN;
          frame_load = 1'b1;
          div_next   = '0;
          bck_next   = 1'b0;
          slot_next  = '0;
          lck_next   = 1'b0;
          din1_next  = 1'b0;
          din2_next  = 1'b0;
        end
      end

      ST_RUN: begin
        div_next = tick ? '0 : div_reg + 1'b1;
        if (tick) bck_next = ~bck_reg;
        // Serial data is MSB-first; the bit leaving the shifter at the wrap is
        // the previous right LSB, which gives the one-slot I2S delay for free.
        if (fall) begin
          din1_next = sh1_reg[FRAME_W-1];
          din2_next = sh2_reg[FRAME_W-1];
          sh1_next  = {sh1_reg[FRAME_W-2:0], 1'b0};
          sh2_next  = {sh2_reg[FRAME_W-2:0], 1'b0};
          if (slot_reg == SLOT_LAST) begin
            slot_next = '0;
            lck_next  = 1'b0;
            if (en) frame_load = 1'b1;
            else    state_next = ST_DRAIN;
          end else begin
            slot_next = slot_inc;
            lck_next  = (slot_inc >= SLOT_HALF);
          end
        end
      end

      ST_DRAIN: begin
        div_next = tick ? '0 : div_reg + 1'b1;
        if (tick) bck_next = ~bck_reg;
        if (fall) begin
          state_next = ST_IDLE;
          din1_next  = 1'b0;
          din2_next  = 1'b0;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // A sample arriving on the wrap edge itself is too late for this frame.
    if (frame_load) begin
      if (hold_full_reg) begin
        sh1_next = {hold_l_reg, hold_r_reg};
        sh2_next = {hold_c_reg, hold_c_reg};
        take     = 1'b1;
      end else begin
        sh1_next      = '0;
        sh2_next      = '0;
        underrun_next = 1'b1;
        if (underrun_cnt_reg != 16'hFFFF) underrun_cnt_next = underrun_cnt_reg + 16'd1;
      end
    end

    if (take) hold_full_next = 1'b0;
    if (accept) begin
      hold_full_next = 1'b1;
      hold_l_next    = sample_l;
      hold_r_next    = sample_r;
      hold_c_next    = sample_c;
    end
  end

  assign ready_next = ~hold_full_next;
  assign busy_next  = (state_next == ST_RUN) || (state_next == ST_DRAIN);

  assign sample_ready = ready_reg;
  assign bck_dac1     = bck_reg;
  assign bck_dac2     = bck_reg;
  assign lck_dac1     = lck_reg;
  assign lck_dac2     = lck_reg;
  assign din_dac1     = din1_reg;
  assign din_dac2     = din2_reg;
  assign busy         = busy_reg;
  assign underrun     = underrun_reg;
  assign underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Scoreboard bench for i2s_frame_scheduler: accepted triples are queued and
// compared against the words reassembled from DIN at each BCK rising edge.
module tb_i2s_frame_scheduler;

  localparam int SW        = 16;
  localparam int DIV       = 2;
  localparam int FRAME_CLK = 4 * SW * DIV;

  typedef struct packed {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic [SW-1:0] c;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [SW-1:0] sample_l, sample_r, sample_c;
  logic          sample_valid;
  logic          sample_ready;
  logic          bck_dac1, lck_dac1, din_dac1;
  logic          bck_dac2, lck_dac2, din_dac2;
  logic          busy, underrun;
  logic [15:0]   underrun_cnt;

  always #5 clk = ~clk;

  i2s_frame_scheduler #(.SAMPLE_W(SW), .BCK_DIV(DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_c     (sample_c),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bck_dac1     (bck_dac1),
    .lck_dac1     (lck_dac1),
    .din_dac1     (din_dac1),
    .bck_dac2     (bck_dac2),
    .lck_dac2     (lck_dac2),
    .din_dac2     (din_dac2),
    .busy         (busy),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  frame_t exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  // ---------------- output monitor ----------------
  int cyc = 0, rise_cnt = 0, rise_slot = -1, ur_pulses = 0, ur_long = 0;
  int slot = 0, last0 = -1, din_glitch = 0, dac2_diff = 0;
  logic busy_q = 1'b0, bck_q = 1'b0, ur_q = 1'b0;
  logic din1_q = 1'b0, din2_q = 1'b0, lck_q = 1'b0;
  logic mon_active = 1'b0, have_frame = 1'b0;
  logic [31:0] acc1 = '0, acc2 = '0, acc_lck = '0;

  task automatic finish_frame();
    frame_t e;
    if (exp_q.size() == 0) begin
      check("sb_size", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check("dac1_words", acc1, {e.l, e.r});
      check("dac2_words", acc2, {e.c, e.c});
      check("lck_pattern", acc_lck, 32'h0001FFFE);
      check("din_stable_bck_high", din_glitch, 0);
      check("dac2_bck_lck_match", dac2_diff, 0);
    end
    din_glitch = 0;
    dac2_diff  = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mon_active = 1'b0;
      busy_q     = 1'b0;
      bck_q      = 1'b0;
      ur_q       = 1'b0;
    end else begin
      if (underrun) begin
        if (!ur_q) ur_pulses++;
        else       ur_long++;
      end
      if (busy && !busy_q) begin
        mon_active = 1'b1;
        slot       = 0;
        have_frame = 1'b0;
        last0      = -1;
        din_glitch = 0;
        dac2_diff  = 0;
      end
      if (bck_dac1 !== bck_dac2 || lck_dac1 !== lck_dac2) dac2_diff++;
      if (mon_active && bck_dac1 && bck_q &&
          (din_dac1 !== din1_q || din_dac2 !== din2_q || lck_dac1 !== lck_q)) din_glitch++;
      if (mon_active && bck_dac1 && !bck_q) begin
        acc1    = {acc1[30:0], din_dac1};
        acc2    = {acc2[30:0], din_dac2};
        acc_lck = {acc_lck[30:0], lck_dac1};
        if (slot == 0) begin
          if (!have_frame) begin
            check("din_b0_first", {din_dac1, din_dac2}, 0);
            have_frame = 1'b1;
          end else begin
            finish_frame();
          end
          if (last0 >= 0) check("frame_clk", cyc - last0, FRAME_CLK);
          last0 = cyc;
        end
        rise_slot = slot;
        rise_cnt++;
        slot = (slot + 1) % (2 * SW);
      end
      busy_q = busy;
      bck_q  = bck_dac1;
      ur_q   = underrun;
      din1_q = din_dac1;
      din2_q = din_dac2;
      lck_q  = lck_dac1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r, input logic [SW-1:0] c);
    bit ok = 1'b0;
    sample_l     = l;
    sample_r     = r;
    sample_c     = c;
    sample_valid = 1'b1;
    for (int i = 0; i < 4 * FRAME_CLK; i++) begin
      if (sample_ready) begin
        @(posedge clk);
        exp_q.push_back(frame_t'{l, r, c});
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    check("send_accept", ok, 1);
  endtask

  task automatic wait_rise(input int s);
    int n0;
    bit ok = 1'b0;
    @(posedge clk);
    n0 = rise_cnt;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      @(posedge clk);
      if (rise_cnt != n0 && rise_slot == s) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("reach_slot%0d", s), ok, 1);
    @(negedge clk);
  endtask

  task automatic wait_underrun(input logic [15:0] exp_cnt);
    int n0;
    bit ok = 1'b0;
    @(posedge clk);
    n0 = ur_pulses;
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      @(posedge clk);
      if (ur_pulses != n0) begin
        ok = 1'b1;
        break;
      end
    end
    check("underrun_seen", ok, 1);
    @(negedge clk);
    check("underrun_cnt", underrun_cnt, exp_cnt);
  endtask

  task automatic wait_busy(input logic val, output int n);
    bit ok = 1'b0;
    n = 0;
    for (int i = 0; i < 4 * FRAME_CLK; i++) begin
      if (busy === val) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    check(val ? "busy_rise" : "busy_fall", ok, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n        = 1'b0;
    en           = 1'b0;
    sample_valid = 1'b0;
    sample_l     = '0;
    sample_r     = '0;
    sample_c     = '0;
    repeat (3) @(negedge clk);
    check("rst_pins", {bck_dac1, lck_dac1, din_dac1, bck_dac2, lck_dac2, din_dac2}, 0);
    check("rst_ready", sample_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_cnt", underrun_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single frame loaded while idle, then EN dropped at b=5
    send(16'h8001, 16'h7FFE, 16'h1234);
    sample_valid = 1'b0;
    check("ready_low_when_full", sample_ready, 0);
    en = 1'b1;
    wait_busy(1'b1, n);
    check("en_to_run_clk", n, 2);
    n = 0;
    for (int i = 0; i < 4 * DIV && din_dac1 !== 1'b1; i++) begin
      @(negedge clk);
      n++;
    end
    check("msb_latency", n, 2 * DIV);
    send(16'hAAAA, 16'h5555, 16'h0F0F);
    sample_valid = 1'b0;
    wait_rise(5);
    en = 1'b0;
    wait_busy(1'b0, n);
    check("idle_pins", {bck_dac1, lck_dac1, din_dac1, bck_dac2, lck_dac2, din_dac2}, 0);
    check("hold_retained", sample_ready, 0);
    check("sb_after_drain", exp_q.size(), 1);
    repeat (5) @(negedge clk);
    check("idle_stays_idle", busy, 0);

    // retained triple plays first, then eight back-to-back frames
    en = 1'b1;
    for (int k = 0; k < 8; k++)
      send(SW'($urandom), SW'($urandom), SW'($urandom));
    sample_valid = 1'b0;
    check("no_underrun_stream", ur_pulses, 0);

    // starvation: three zero frames, then resume
    repeat (3) exp_q.push_back('0);
    for (int k = 1; k <= 3; k++) wait_underrun(16'(k));
    check("underrun_one_clk", ur_long, 0);
    send(16'hC0DE, 16'h0001, 16'hFFFF);
    send(16'h1357, 16'h2468, 16'h8000);
    sample_valid = 1'b0;
    check("resume_no_underrun", ur_pulses, 3);

    // saturation: preload the counter near full
    wait_rise(5);
    force dut.underrun_cnt_reg = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.underrun_cnt_reg;
    @(negedge clk);
    check("cnt_preload", underrun_cnt, 16'hFFFE);
    repeat (2) exp_q.push_back('0);
    wait_underrun(16'hFFFF);
    wait_underrun(16'hFFFF);

    // asynchronous reset in the middle of a frame
    send(16'h4242, 16'hBDBD, 16'h7777);
    send(16'h0F0F, 16'hF0F0, 16'h3C3C);
    sample_valid = 1'b0;
    wait_rise(10);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_pins", {bck_dac1, lck_dac1, din_dac1, bck_dac2, lck_dac2, din_dac2}, 0);
    check("midrst_ready", sample_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_underrun", underrun, 0);
    check("midrst_cnt", underrun_cnt, 0);
    exp_q.delete();
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", fails);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_frame_scheduler.md
# i2s_frame_scheduler

Sequences the I2S streams for both PCM5102A DACs from one sample interface: generates the shared bit clock and word-select, serialises Left/Right onto DAC1 and Center onto DAC2 frame-aligned, and zero-fills frames when the producer underruns. It sits between the ESP32-side sample source (SD-card decoder) and the DAC1/DAC2 BCK/LCK/DIN pins.

## Interface
- SAMPLE_W, 16: bits per channel word; frame = 2*SAMPLE_W BCK periods.
- BCK_DIV, 4: CLK cycles per BCK half-period (>=1); BCK period = 2*BCK_DIV CLK.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- EN  in  1  run request.
- SAMPLE_L / SAMPLE_R / SAMPLE_C  in  SAMPLE_W each  two's-complement samples, one triple per frame.
- SAMPLE_VALID  in  1  triple valid.
- SAMPLE_READY  out  1  registered; high when one-entry holding register is empty.
- BCK_DAC1, LCK_DAC1, DIN_DAC1  out  1  DAC1 I2S (L/R).
- BCK_DAC2, LCK_DAC2, DIN_DAC2  out  1  DAC2 I2S; BCK/LCK identical to DAC1.
- BUSY  out  1  high in RUN or DRAIN.
- UNDERRUN  out  1  one-CLK pulse per zero-filled frame.
- UNDERRUN_CNT  out  16  saturating underrun count.

## Operation
- Handshake: transfer on CLK edge with SAMPLE_VALID & SAMPLE_READY; triple stored in holding register, READY falls next cycle; READY rises the cycle after the frame load empties it.
- Slot counter b = 0..2*SAMPLE_W-1, advanced on every BCK falling edge, wraps to 0.
- LCK = 0 for b < SAMPLE_W (left), 1 otherwise. Standard I2S one-bit delay: word MSB at b=1 (left) / b=SAMPLE_W+1 (right); LSB of left at b=SAMPLE_W, LSB of right at b=0 of next frame (or DRAIN slot).
- DAC1 left = SAMPLE_L, right = SAMPLE_R; DAC2 left and right both = SAMPLE_C.
- Frame load at wrap edge (b -> 0) and at WAIT->RUN: if holding full, shift registers load it and holding empties; else load all-zero words, pulse UNDERRUN, UNDERRUN_CNT += 1 (saturate at 0xFFFF).
- States:
  - IDLE: BCK/LCK/DIN = 0. EN=1 -> WAIT.
  - WAIT: outputs 0; holding full -> RUN (load, b=0, DIN=0 at b=0); EN=0 -> IDLE.
  - RUN: BCK toggles; EN sampled at wrap edge: EN=0 -> DRAIN instead of loading (no underrun counted).
  - DRAIN: one BCK period with b=0, LCK=0, DIN = last right LSB; then IDLE, all outputs 0.
- Holding register contents survive IDLE; UNDERRUN_CNT cleared only by reset.

## Timing
- Reset (async, immediate even mid-frame): BCK/LCK/DIN both DACs = 0, SAMPLE_READY=1, BUSY=0, UNDERRUN=0, UNDERRUN_CNT=0, state IDLE, holding empty.
- Entering RUN: BCK=0, b=0; first BCK rise BCK_DIV CLK later; BCK falls every 2*BCK_DIV CLK; DIN/LCK change only with BCK falling (same CLK edge), stable at BCK rise.
- Latency: triple accepted in WAIT -> RUN next CLK, left MSB on DIN 2*BCK_DIV CLK later (b=1).
- Sample written on the same CLK edge as a wrap with holding empty: frame underruns, sample kept for following frame.
- Throughput: one triple per 4*SAMPLE_W*BCK_DIV CLK.
- BUSY high from WAIT->RUN edge through last DRAIN cycle.

## Test plan
- Reset mid-frame (SAMPLE_W=16, BCK_DIV=2): assert RST_N=0 at b=10 -> all pins 0 same cycle, READY=1, CNT=0.
- Single frame: L=0x8001, R=0x7FFE, C=0x1234, EN=1 -> DIN_DAC1 bits b1..b16 = 8001 MSB-first, b17..b31 + DRAIN = 7FFE; DIN_DAC2 = 1234 both slots; BCK period 4 CLK, frame 128 CLK.
- Continuous streaming, VALID always high: 8 frames back-to-back, no UNDERRUN, right LSB of frame n at b=0 of frame n+1.
- Starvation: stop VALID after frame 2 -> frames 3+ all-zero, UNDERRUN pulse per frame, CNT=1,2,...; resume -> data on next wrap.
- Saturation: preload CNT path with 65540 underrun frames (or force) -> CNT holds 0xFFFF.
- EN drop at b=5 -> frame completes, DRAIN emits right LSB, IDLE with outputs 0; holding triple retained and played first after EN=1.
